sm_move_ctrl: RTL
=================

Name: sm_move_ctrl

Overview:
- Move controller for the stepper motor (SM) drive path; sits directly downstream of the step-pulse generator and closes the loop back to it.
- Accepts a move command (step count, direction, step mode) over a valid/ready handshake.
- Asserts the generator's enable and consumes its drv_step pulses. Each pulse advances the coil phase pattern and the signed position counter.
- Stops the generator after the commanded number of steps, or on abort. Holds the coils for a settle time, then reports done.

Parameters:
CNT_W, 16, width of commanded step count and steps_left
POS_W, 24, width of signed absolute position counter (two's complement, wraps)
SETTLE_CYC, 50000, clk cycles coils stay energised after a move (1 ms at 50 MHz); minimum 1
IDLE_OFF, 1, 1: phase outputs 4'b0000 in IDLE; 0: last pattern held in IDLE

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command (IDLE only)
cmd_steps  in  CNT_W  number of steps to move, unsigned
cmd_dir  in  1  1 = forward (+position), 0 = reverse
cmd_half  in  1  1 = half-step, 0 = full-step; sampled with command
abort  in  1  level; terminates RUN
drv_step  in  1  step pulse from step generator, same clock domain
drv_enable  out  1  enable to step generator
phase  out  4  coil drive {A, B, A_n, B_n}
position  out  POS_W  signed step position
steps_left  out  CNT_W  remaining steps of current move
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of move
aborted  out  1  valid with done; 1 if move ended by abort

Behaviour:
- Reset (rst=0, async) values:
  - state IDLE; drv_enable 0; index 0; position 0; steps_left 0; done 0; aborted 0; drv_step_d 0.
  - phase is 0000 if IDLE_OFF=1, else 1000.
- All outputs are registered.
- Step event: step_evt = drv_step & ~drv_step_d (rising edge), counted only in RUN. A drv_step held high counts once.
- Phase table, index 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
- Index update per step:
  - Half-step: ±1 mod 8.
  - Full-step: ±2 mod 8; parity is preserved, so an odd start index gives two-phase-on full steps.
  - Forward increments, reverse decrements.
- Position changes ±1 per step (one step = one event, independent of mode) and wraps at POS_W.
- IDLE:
  - cmd_ready=1.
  - Accept (cmd_valid & cmd_ready) with cmd_steps=0: done=1 and aborted=0 on the next cycle; stay IDLE; drv_enable is never raised.
  - Accept with cmd_steps>0: latch dir, half and steps; steps_left=cmd_steps. Next cycle: RUN, drv_enable=1, busy=1.
  - phase is driven from the table immediately on entering RUN.
- RUN:
  - On step_evt in cycle n: index, phase, position and steps_left update at n+1.
  - If steps_left was 1, drv_enable=0 at n+1 and state goes to SETTLE, so no further step is counted.
  - abort=1: next cycle drv_enable=0, state SETTLE, aborted flag set; steps_left is retained (not cleared).
  - abort and step_evt in the same cycle: abort wins; that step is not applied.
- SETTLE:
  - Counter runs SETTLE_CYC cycles; phase held; cmd_ready=0; drv_step ignored.
  - On expiry: done=1 for one cycle with aborted valid, state IDLE; phase blanks if IDLE_OFF=1.
  - aborted holds until the next accept.
- cmd_valid while busy: ignored; the command stays pending until IDLE.
- Reset asserted mid-move: immediate return to reset values; drv_enable drops asynchronously.
- Index and direction persist across moves, so the next move continues from the last pattern.

Decomposition:
- Shared package sm_pkg:
  - state enum {IDLE, RUN, SETTLE}.
  - 8x4 phase table constant.
  - DIR_FWD/DIR_REV constants.
  - Default widths CNT_W/POS_W.
- One natural sub-module: sm_phase_table (3-bit index in, 4-bit pattern out, combinational), reused by other SM channels.
- The FSM, counters and edge detect stay in sm_move_ctrl.

Test Plan:
- Reset then idle check (SETTLE_CYC=8, IDLE_OFF=1) -> phase=0000, cmd_ready=1, drv_enable=0, position=0.
- Forward half-step move: cmd_steps=5, dir=1, half=1; drv_step pulses every 10 clk:
  - phase sequence 1100, 0100, 0110, 0010, 0011; position=5.
  - drv_enable drops the cycle after the 5th pulse; done pulses 8 clk later; aborted=0.
- Reverse full-step move: from index 5, cmd_steps=3, dir=0, half=0:
  - index 3, 1, 7; phase 0110, 1100, 1001; position 5→2.
- Abort: cmd_steps=100, abort asserted coincident with the 4th step edge:
  - 3 steps applied, steps_left=97, drv_enable=0 next cycle, done with aborted=1 after settle.
- Edge/handshake cases:
  - drv_step held high 5 cycles -> one step.
  - cmd_steps=0 -> done next cycle, drv_enable never 1.
  - cmd_valid during SETTLE -> accepted only on the first IDLE cycle.
- Wrap, async reset and mode change:
  - POS_W=4, position=7, one forward step -> -8.
  - rst low mid-RUN -> drv_enable=0 without a clock edge; all outputs at reset values.
  - Half-step move started from odd index -> sequence correct.

Source files
------------

// File: rtl/sm_pkg.sv
// sm_pkg: shared types, phase table and defaults for the stepper motor channels
package sm_pkg;
  typedef enum logic [1:0] {IDLE, RUN, SETTLE} state_t;
  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;
  localparam int SM_CNT_W = 16;
  localparam int SM_POS_W = 24;
  localparam logic [7:0][3:0] PHASE_TAB = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100, 4'b1000
  };
  // Full steps move two entries so an odd start index stays on two-phase-on patterns
  function automatic logic [2:0] next_idx(input logic [2:0] idx, input logic dir, input logic half);
    logic [2:0] inc;
    inc = half ? 3'd1 : 3'd2;
    return (dir == DIR_FWD) ? idx + inc : idx - inc;
  endfunction
endpackage

// File: rtl/sm_phase_table.sv
// sm_phase_table: 3-bit coil index to {A, B, A_n, B_n} drive pattern
module sm_phase_table
  import sm_pkg::*;
(
  input  logic [2:0] idx,
  output logic [3:0] pat
);
  assign pat = PHASE_TAB[idx];
endmodule

// File: rtl/sm_move_ctrl.sv
// sm_move_ctrl: runs one commanded move on the step generator, tracks coil phase and position
module sm_move_ctrl
  import sm_pkg::*;
#(
  parameter int CNT_W      = SM_CNT_W,
  parameter int POS_W      = SM_POS_W,
  parameter int SETTLE_CYC = 50000,
  parameter bit IDLE_OFF   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic             cmd_half,
  input  logic             abort,
  input  logic             drv_step,
  output logic             drv_enable,
  output logic [3:0]       phase,
  output logic [POS_W-1:0] position,
  output logic [CNT_W-1:0] steps_left,
  output logic             busy,
  output logic             done,
  output logic             aborted
);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYC - 1);
  localparam logic [3:0] PHASE_RST = IDLE_OFF ? 4'b0000 : 4'b1000;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [3:0]       phase_q, phase_d, pat;
  logic             dir_q, dir_d, half_q, half_d;
  logic             en_q, en_d, done_q, done_d, aborted_q, aborted_d;
  logic             ready_q, ready_d, busy_q, busy_d, drv_step_q;
  logic             step_evt, accept;

  sm_phase_table u_tab (.idx(idx_d), .pat(pat));

  always_comb begin
    step_evt  = drv_step & ~drv_step_q;
    accept    = cmd_valid & ready_q;
    state_d   = state_q;
    idx_d     = idx_q;
    pos_d     = pos_q;
    left_d    = left_q;
    set_d     = set_q;
    dir_d     = dir_q;
    half_d    = half_q;
    en_d      = en_q;
    done_d    = 1'b0;
    aborted_d = aborted_q;
    case (state_q)
      IDLE: if (accept) begin
        aborted_d = 1'b0;
        done_d    = (cmd_steps == '0);
        if (cmd_steps != '0) begin
          state_d = RUN;
          en_d    = 1'b1;
          left_d  = cmd_steps;
          dir_d   = cmd_dir;
          half_d  = cmd_half;
        end
      end
      RUN: if (abort) begin
        state_d   = SETTLE;
        en_d      = 1'b0;
        aborted_d = 1'b1;
        set_d     = SET_LOAD;
      end else if (step_evt) begin
        idx_d  = next_idx(idx_q, dir_q, half_q);
        pos_d  = (dir_q == DIR_FWD) ? pos_q + 1'b1 : pos_q - 1'b1;
        left_d = left_q - 1'b1;
        if (left_q == CNT_W'(1)) begin
          state_d = SETTLE;
          en_d    = 1'b0;
          set_d   = SET_LOAD;
        end
      end
      SETTLE: if (set_q == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        set_d = set_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    phase_d = (state_d == IDLE) ? (IDLE_OFF ? 4'b0000 : phase_q) : pat;
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      pos_q      <= '0;
      left_q     <= '0;
      set_q      <= '0;
      phase_q    <= PHASE_RST;
      dir_q      <= DIR_FWD;
      half_q     <= 1'b0;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      drv_step_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pos_q      <= pos_d;
      left_q     <= left_d;
      set_q      <= set_d;
      phase_q    <= phase_d;
      dir_q      <= dir_d;
      half_q     <= half_d;
      en_q       <= en_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      drv_step_q <= drv_step;
    end
  end

  assign cmd_ready  = ready_q;
  assign drv_enable = en_q;
  assign phase      = phase_q;
  assign position   = pos_q;
  assign steps_left = left_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
endmodule
